// File: rtl/sram_uart_dump.sv
// Streams a block of SRAM words out of an 8N1 UART transmitter, high byte first.
// One SRAM read per word, then two back-to-back serial frames, read-only on SRAM.
module sram_uart_dump #(
    parameter int CLKS_PER_BIT      = 434,
    parameter int SRAM_READ_LATENCY = 2
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Length,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX,
    output logic        Busy,
    output logic        Done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int LAT_W  = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [17:0]         addr;
    logic [17:0]         remaining;
    logic [LAT_W-1:0]    lat_cnt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [3:0]          bit_idx;
    logic [15:0]         word_buf;
    logic [7:0]          cur_byte;
    logic                byte_end;
    logic                capture;

    assign SRAM_we_n = 1'b1;
    assign cur_byte  = (state == S_TX_HI) ? word_buf[15:8] : word_buf[7:0];
    assign byte_end  = (baud_cnt == '0) && (bit_idx == 4'd9);
    assign capture   = (state == S_WAIT) && (lat_cnt == '0);

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start && (Length != 18'd0)) state_next = S_READ;
            S_READ:  state_next = S_WAIT;
            S_WAIT:  if (lat_cnt == '0) state_next = S_TX_HI;
            S_TX_HI: if (byte_end) state_next = S_TX_LO;
            S_TX_LO: if (byte_end) state_next = (remaining == 18'd1) ? S_DONE : S_READ;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            addr         <= '0;
            remaining    <= '0;
            SRAM_address <= '0;
            lat_cnt      <= '0;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            UART_TX      <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Length != 18'd0) begin
                            addr         <= Base_address;
                            remaining    <= Length;
                            SRAM_address <= Base_address;
                            Busy         <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end
                S_READ: lat_cnt <= LAT_W'(SRAM_READ_LATENCY - 1);
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        // Start bit must be on the line in the first TX_HI cycle.
                        UART_TX  <= 1'b0;
                        baud_cnt <= BAUD_W'(CLKS_PER_BIT - 1);
                        bit_idx  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_TX_HI, S_TX_LO: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        baud_cnt <= BAUD_W'(CLKS_PER_BIT - 1);
                        if (bit_idx == 4'd9) begin
                            bit_idx <= '0;
                            if (state == S_TX_HI) begin
                                UART_TX <= 1'b0;
                            end else begin
                                UART_TX      <= 1'b1;
                                remaining    <= remaining - 18'd1;
                                addr         <= addr + 18'd1;
                                SRAM_address <= addr + 18'd1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            UART_TX <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                        end
                    end
                end
                S_DONE: begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock_50) begin
        if (capture) word_buf <= SRAM_read_data;
    end

endmodule
